// File: rtl/seq_multiplier_n_if.sv
// Operand/result bundle for the sequential multiplier: load/run controls in, product and status out.
// master drives controls and operand, slave (the multiplier) drives registers and status.
interface seq_multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic                 ClearA_LoadB;
    logic                 Run;
    logic [WIDTH-1:0]     S;
    logic [WIDTH-1:0]     Aval;
    logic [WIDTH-1:0]     Bval;
    logic                 X;
    logic [2*WIDTH-1:0]   Product;
    logic                 Busy;
    logic                 Done;

    modport master (
        output ClearA_LoadB, Run, S,
        input  Aval, Bval, X, Product, Busy, Done
    );

    modport slave (
        input  ClearA_LoadB, Run, S,
        output Aval, Bval, X, Product, Busy, Done
    );
endinterface

// File: rtl/seq_multiplier_n.sv
// Add-shift multiplier: product of S (captured as M) and B, one bit per cycle, result in {X, A, B}.
// Latency: WIDTH cycles of Busy after Run is sampled, then a 1-cycle Done on entry to HOLD.
// Backpressure: result is held in HOLD while Run stays high; inputs are ignored during CALC.
module seq_multiplier_n #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    seq_multiplier_n_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  m_q;
    logic              x_q;
    logic              done_q;

    logic [WIDTH-1:0]  addend;
    logic [WIDTH:0]    addend_ext;
    logic [WIDTH:0]    acc;
    logic [WIDTH:0]    sum;
    logic              last_step;

    always_comb begin
        addend     = b_q[0] ? m_q : '0;
        addend_ext = SIGNED ? {addend[WIDTH-1], addend} : {1'b0, addend};
        acc        = SIGNED ? {x_q, a_q} : {1'b0, a_q};
        last_step  = (count_q == LAST);
        // Two's-complement multiplier: the sign bit of B carries weight -2^(W-1), so the last partial product is subtracted.
        if (SIGNED && last_step) begin
            sum = acc - addend_ext;
        end else begin
            sum = acc + addend_ext;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ClearA_LoadB) begin
                        x_q <= 1'b0;
                        a_q <= '0;
                        b_q <= bus.S;
                    end else if (bus.Run) begin
                        m_q     <= bus.S;
                        a_q     <= '0;
                        x_q     <= 1'b0;
                        count_q <= '0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Unsigned mode: sum[WIDTH] is the carry, shifted into A's MSB; X stays 0.
                    x_q     <= SIGNED ? sum[WIDTH] : 1'b0;
                    a_q     <= sum[WIDTH:1];
                    b_q     <= {sum[0], b_q[WIDTH-1:1]};
                    count_q <= count_q + CW'(1);
                    if (last_step) begin
                        state_q <= ST_HOLD;
                        done_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!bus.Run) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Aval    = a_q;
    assign bus.Bval    = b_q;
    assign bus.X       = x_q;
    assign bus.Product = {a_q, b_q};
    assign bus.Busy    = (state_q == ST_CALC);
    assign bus.Done    = done_q;
endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed bench for seq_multiplier_n: an arithmetic reference model checked every cycle on the 8-bit signed
// instance, plus literal expectations on it and on 8-bit unsigned and 16-bit signed instances.
module tb_seq_multiplier_n;
    logic clk;
    logic rst_n;

    seq_multiplier_n_if #(.WIDTH(8))  m_if ();
    seq_multiplier_n_if #(.WIDTH(8))  u_if ();
    seq_multiplier_n_if #(.WIDTH(16)) w_if ();

    seq_multiplier_n #(.WIDTH(8),  .SIGNED(1'b1)) u_dut_s8  (.Clk(clk), .Reset(rst_n), .bus(m_if));
    seq_multiplier_n #(.WIDTH(8),  .SIGNED(1'b0)) u_dut_u8  (.Clk(clk), .Reset(rst_n), .bus(u_if));
    seq_multiplier_n #(.WIDTH(16), .SIGNED(1'b1)) u_dut_s16 (.Clk(clk), .Reset(rst_n), .bus(w_if));

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int busy_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 holding. The product comes from plain integer arithmetic.
    int          m_phase = 0;
    int          m_left = 0;
    int          m_prod = 0;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic        m_x = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_pend = '0;
    logic        m_pend_x = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_a     = '0;
            m_b     = '0;
            m_x     = 1'b0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                0: begin
                    if (m_if.ClearA_LoadB) begin
                        m_a = '0;
                        m_b = m_if.S;
                        m_x = 1'b0;
                    end else if (m_if.Run) begin
                        m_prod   = int'($signed(m_b)) * int'($signed(m_if.S));
                        m_pend   = m_prod[15:0];
                        m_pend_x = (m_prod < 0);
                        m_phase  = 1;
                        m_left   = 8;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_a, m_b} = m_pend;
                        m_x        = m_pend_x;
                        m_done     = 1'b1;
                        m_phase    = 2;
                    end
                end
                default: begin
                    if (!m_if.Run) m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", m_if.Busy, m_phase == 1);
        chk("done", m_if.Done, m_done);
        if (m_phase != 1) begin
            chk("aval", m_if.Aval, m_a);
            chk("bval", m_if.Bval, m_b);
            chk("x", m_if.X, m_x);
            chk("product", m_if.Product, {m_a, m_b});
        end
        if (m_if.Done) done_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [7:0] v);
        m_if.ClearA_LoadB = 1'b1;
        m_if.S = v;
        step(1);
        m_if.ClearA_LoadB = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        busy_n = 0;
        while (n < 40 && !found) begin
            @(negedge clk);
            if (m_if.Busy) busy_n++;
            if (m_if.Done) found = 1'b1;
            n++;
        end
        chk({tag, "_done_seen"}, found, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] s, input logic [7:0] ea,
                          input logic [7:0] eb, input logic ex);
        m_if.S = s;
        m_if.Run = 1'b1;
        step(1);
        m_if.S = ~s;
        wait_done(tag);
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_aval"}, m_if.Aval, ea);
        chk({tag, "_bval"}, m_if.Bval, eb);
        chk({tag, "_x"}, m_if.X, ex);
        step(1);
        m_if.Run = 1'b0;
        step(1);
    endtask

    task automatic u_run(input logic [7:0] ld, input logic [7:0] s, input logic [15:0] ep);
        int n;
        n = 0;
        u_if.ClearA_LoadB = 1'b1;
        u_if.S = ld;
        step(1);
        u_if.ClearA_LoadB = 1'b0;
        u_if.S = s;
        u_if.Run = 1'b1;
        step(1);
        u_if.Run = 1'b0;
        while (n < 40 && !u_if.Done) begin
            @(negedge clk);
            n++;
        end
        chk("u8_done_seen", u_if.Done, 1'b1);
        chk("u8_product", u_if.Product, ep);
        chk("u8_x", u_if.X, 1'b0);
        step(2);
    endtask

    task automatic w_run(input logic [15:0] ld, input logic [15:0] s, input logic [31:0] ep, input logic ex);
        int n;
        n = 0;
        w_if.ClearA_LoadB = 1'b1;
        w_if.S = ld;
        step(1);
        w_if.ClearA_LoadB = 1'b0;
        w_if.S = s;
        w_if.Run = 1'b1;
        step(1);
        w_if.Run = 1'b0;
        while (n < 60 && !w_if.Done) begin
            @(negedge clk);
            n++;
        end
        chk("s16_done_seen", w_if.Done, 1'b1);
        chk("s16_product", w_if.Product, ep);
        chk("s16_x", w_if.X, ex);
        step(2);
    endtask

    initial begin
        int d0;
        rst_n = 1'b1;
        m_if.ClearA_LoadB = 1'b0; m_if.Run = 1'b0; m_if.S = '0;
        u_if.ClearA_LoadB = 1'b0; u_if.Run = 1'b0; u_if.S = '0;
        w_if.ClearA_LoadB = 1'b0; w_if.Run = 1'b0; w_if.S = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_product", m_if.Product, 16'h0000);
        chk("rst_flags", {m_if.X, m_if.Busy, m_if.Done}, 3'b000);
        step(2);
        rst_n = 1'b1;

        // reset after a load clears B again
        load(8'h5A);
        chk("load_bval", m_if.Bval, 8'h5A);
        rst_n = 1'b0;
        #1;
        chk("rst2_product", m_if.Product, 16'h0000);
        chk("rst2_flags", {m_if.X, m_if.Busy, m_if.Done}, 3'b000);
        step(1);
        rst_n = 1'b1;

        // 7 x 59, then chain the low half 0x9D (-99) x 2
        load(8'h07);
        run_op("pos_pos", 8'h3B, 8'h01, 8'h9D, 1'b0);
        run_op("chain", 8'h02, 8'hFF, 8'h3A, 1'b1);

        load(8'h07);
        run_op("pos_neg", 8'hC5, 8'hFE, 8'h63, 1'b1);
        load(8'hF9);
        run_op("neg_neg", 8'hC5, 8'h01, 8'h9D, 1'b0);
        load(8'h80);
        run_op("min_min", 8'h80, 8'h40, 8'h00, 1'b0);

        // reset during the fourth computing cycle aborts without a Done pulse
        load(8'h03);
        m_if.S = 8'h05;
        m_if.Run = 1'b1;
        step(4);
        chk("abort_busy_before", m_if.Busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_product", m_if.Product, 16'h0000);
        chk("abort_flags", {m_if.X, m_if.Busy, m_if.Done}, 3'b000);
        m_if.Run = 1'b0;
        d0 = done_seen;
        step(1);
        rst_n = 1'b1;
        step(12);
        chk("abort_no_done", done_seen - d0, 0);

        // Run held high across completion gives one operation
        load(8'h03);
        m_if.S = 8'h04;
        m_if.Run = 1'b1;
        d0 = done_seen;
        step(30);
        chk("held_done_count", done_seen - d0, 1);
        chk("held_product", m_if.Product, 16'h000C);
        m_if.Run = 1'b0;
        step(1);

        // load and Run together: load only
        m_if.ClearA_LoadB = 1'b1;
        m_if.Run = 1'b1;
        m_if.S = 8'h21;
        d0 = done_seen;
        step(1);
        m_if.ClearA_LoadB = 1'b0;
        m_if.Run = 1'b0;
        step(12);
        chk("loadrun_busy", m_if.Busy, 1'b0);
        chk("loadrun_product", m_if.Product, 16'h0021);
        chk("loadrun_no_done", done_seen - d0, 0);

        u_run(8'hFF, 8'hFF, 16'hFE01);
        u_run(8'h80, 8'h03, 16'h0180);
        w_run(16'h1234, 16'h0010, 32'h0001_2340, 1'b0);
        w_run(16'hFFFF, 16'h1234, 32'hFFFF_EDCC, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "bench time limit reached");
    end
endmodule
